// File: rtl/sram_image_burst_if.sv
// ---------------------------------------------------------------------------
// sram_image_burst_if
//   Bundles the burst-read handshake, the pixel write port and the read-data
//   return path of the 2D image store.
//   master : image loader / window fetcher side (drives req, coordinates,
//            write strobe and data; receives busy, wready and read data)
//   slave  : the image store itself
//   Signals: req, x_start, y_start, burst_len, busy, wen, w_x, w_y, wdat,
//            wready, rvalid, rdat, rlast
// ---------------------------------------------------------------------------
interface sram_image_burst_if #(
  parameter int PIXEL_DEPTH = 8,
  parameter int COORD_W     = 5,
  parameter int LEN_W       = 4
) ();
  logic                      req;
  logic signed [COORD_W-1:0] x_start;
  logic signed [COORD_W-1:0] y_start;
  logic [LEN_W-1:0]          burst_len;
  logic                      busy;
  logic                      wen;
  logic signed [COORD_W-1:0] w_x;
  logic signed [COORD_W-1:0] w_y;
  logic [PIXEL_DEPTH-1:0]    wdat;
  logic                      wready;
  logic                      rvalid;
  logic [PIXEL_DEPTH-1:0]    rdat;
  logic                      rlast;

  modport master (
    output req, x_start, y_start, burst_len, wen, w_x, w_y, wdat,
    input  busy, wready, rvalid, rdat, rlast
  );

  modport slave (
    input  req, x_start, y_start, burst_len, wen, w_x, w_y, wdat,
    output busy, wready, rvalid, rdat, rlast
  );
endinterface

// File: rtl/sram_image_burst.sv
// ---------------------------------------------------------------------------
// sram_image_burst
//   2D image store with signed coordinates and row-burst reads. A synchronous
//   1D pixel array (addr = x + y*X_MAX) sits behind a req/busy/rvalid
//   handshake. A burst reads burst_len pixels along one row, one per cycle,
//   with one cycle of read latency. Out-of-frame reads return zero, or, when
//   SRAM_IMAGE_CLAMP_EN is defined, the nearest edge pixel (x and y clamped
//   independently). Writes outside the frame are dropped, never clamped.
//
// Ports
//   ramclk : clock, all logic on the rising edge
//   n_rst  : synchronous active-low reset
//   bus    : sram_image_burst_if.slave (request, write port, read return)
//
// Optional feature macro: SRAM_IMAGE_CLAMP_EN (edge-clamp out-of-frame reads)
// The pixel array is named `ram` so a bench can reach it by hierarchy.
// ---------------------------------------------------------------------------
module sram_image_burst #(
  parameter int PIXEL_DEPTH = 8,
  parameter int X_MAX       = 5,
  parameter int Y_MAX       = 5,
  parameter int MAX_BURST   = 8,
  parameter int COORD_W     = $clog2((X_MAX > Y_MAX) ? X_MAX : Y_MAX) + 2,
  parameter int LEN_W       = $clog2(MAX_BURST) + 1
) (
  input  logic               ramclk,
  input  logic               n_rst,
  sram_image_burst_if.slave  bus
);

  // One extra bit so x_start + k can never wrap back into the frame.
  localparam int CW1    = COORD_W + 1;
  localparam int NPIX   = X_MAX * Y_MAX;
  localparam int ADDR_W = (NPIX > 1) ? $clog2(NPIX) : 1;

  localparam logic signed [CW1-1:0] C_ZERO  = '0;
  localparam logic signed [CW1-1:0] C_ONE   = CW1'(1);
  localparam logic signed [CW1-1:0] X_LIM   = CW1'(X_MAX);
  localparam logic signed [CW1-1:0] Y_LIM   = CW1'(Y_MAX);
  localparam logic [LEN_W-1:0]      LEN_MAX = LEN_W'(MAX_BURST);
  localparam logic [LEN_W-1:0]      LEN_ONE = LEN_W'(1);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  logic [PIXEL_DEPTH-1:0] ram [0:NPIX-1];

  state_t                 state_r;
  state_t                 state_nxt_s;
  logic signed [CW1-1:0]  x_r;
  logic signed [CW1-1:0]  y_r;
  logic [LEN_W-1:0]       cnt_r;
  logic                   rvalid_r;
  logic                   rlast_r;
  logic [PIXEL_DEPTH-1:0] rdat_r;

  logic                   req_ok_s;
  logic                   accept_s;
  logic                   issue_s;
  logic                   last_s;
  logic                   ren_s;
  logic signed [CW1-1:0]  rd_x_s;
  logic signed [CW1-1:0]  rd_y_s;
  logic [ADDR_W-1:0]      rd_addr_s;
  logic signed [CW1-1:0]  wx_s;
  logic signed [CW1-1:0]  wy_s;
  logic [ADDR_W-1:0]      wr_addr_s;
  logic                   wready_s;
  logic                   wr_en_s;

  function automatic logic in_frame(input logic signed [CW1-1:0] x,
                                    input logic signed [CW1-1:0] y);
    return (x >= C_ZERO) && (x < X_LIM) && (y >= C_ZERO) && (y < Y_LIM);
  endfunction

  // Only meaningful for in-frame coordinates; callers gate on in_frame().
  function automatic logic [ADDR_W-1:0] pix_addr(input logic signed [CW1-1:0] x,
                                                 input logic signed [CW1-1:0] y);
    logic [CW1-1:0] xu;
    logic [CW1-1:0] yu;
    xu = unsigned'(x);
    yu = unsigned'(y);
    return ADDR_W'(xu) + ADDR_W'(yu) * ADDR_W'(X_MAX);
  endfunction

`ifdef SRAM_IMAGE_CLAMP_EN
  function automatic logic signed [CW1-1:0] clamp_coord(input logic signed [CW1-1:0] v,
                                                        input logic signed [CW1-1:0] lim);
    logic signed [CW1-1:0] r;
    if (v < C_ZERO) begin
      r = C_ZERO;
    end else if (v >= lim) begin
      r = lim - C_ONE;
    end else begin
      r = v;
    end
    return r;
  endfunction
`endif

  // Request qualification, read-issue address and write-port gating.
  always_comb begin
    req_ok_s  = bus.req && (bus.burst_len != '0) && (bus.burst_len <= LEN_MAX);
    accept_s  = (state_r == IDLE) && req_ok_s;
    issue_s   = (state_r == BURST);
    last_s    = issue_s && (cnt_r == LEN_ONE);
`ifdef SRAM_IMAGE_CLAMP_EN
    rd_x_s    = clamp_coord(x_r, X_LIM);
    rd_y_s    = clamp_coord(y_r, Y_LIM);
    ren_s     = issue_s;
`else
    rd_x_s    = x_r;
    rd_y_s    = y_r;
    ren_s     = issue_s && in_frame(x_r, y_r);
`endif
    rd_addr_s = pix_addr(rd_x_s, rd_y_s);
    wx_s      = {bus.w_x[COORD_W-1], bus.w_x};
    wy_s      = {bus.w_y[COORD_W-1], bus.w_y};
    wr_addr_s = pix_addr(wx_s, wy_s);
    // Writes are locked out during a burst and in any cycle a request is pending.
    wready_s  = (state_r == IDLE) && !bus.req;
    wr_en_s   = bus.wen && wready_s && in_frame(wx_s, wy_s);
  end

  // Next-state logic: stay in BURST until the last pixel has been issued.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (req_ok_s) begin
          state_nxt_s = BURST;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      BURST: begin
        if (last_s) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = BURST;
        end
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge ramclk) begin
    if (!n_rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Burst cursor and registered read-return path.
  always_ff @(posedge ramclk) begin
    if (!n_rst) begin
      x_r      <= '0;
      y_r      <= '0;
      cnt_r    <= '0;
      rvalid_r <= 1'b0;
      rlast_r  <= 1'b0;
      rdat_r   <= '0;
    end else begin
      rvalid_r <= issue_s;
      rlast_r  <= last_s;
      // rdat only moves on a read, so it holds between bursts.
      if (issue_s) begin
        rdat_r <= ren_s ? ram[rd_addr_s] : '0;
      end
      if (accept_s) begin
        x_r   <= {bus.x_start[COORD_W-1], bus.x_start};
        y_r   <= {bus.y_start[COORD_W-1], bus.y_start};
        cnt_r <= bus.burst_len;
      end else if (issue_s) begin
        x_r   <= x_r + C_ONE;
        cnt_r <= cnt_r - LEN_ONE;
      end
    end
  end

  // Pixel array write port; contents are not affected by reset.
  always_ff @(posedge ramclk) begin
    if (wr_en_s) begin
      ram[wr_addr_s] <= bus.wdat;
    end
  end

  assign bus.busy   = (state_r == BURST);
  assign bus.wready = wready_s;
  assign bus.rvalid = rvalid_r;
  assign bus.rlast  = rlast_r;
  assign bus.rdat   = rdat_r;

endmodule

// File: tb/tb_sram_image_burst.sv
module tb_sram_image_burst;

  localparam int PD      = 8;
  localparam int XM      = 5;
  localparam int YM      = 5;
  localparam int MB      = 8;
  localparam int COORD_W = 5;
  localparam int LEN_W   = 4;

  logic ramclk;
  logic n_rst;

  int total;
  int bad;

  logic [PD-1:0] mem [0:XM*YM-1];
  logic [PD:0]   exp_q[$];
  logic [PD:0]   mon_e;

  sram_image_burst_if #(.PIXEL_DEPTH(PD), .COORD_W(COORD_W), .LEN_W(LEN_W)) bus ();

  sram_image_burst #(
    .PIXEL_DEPTH(PD), .X_MAX(XM), .Y_MAX(YM), .MAX_BURST(MB),
    .COORD_W(COORD_W), .LEN_W(LEN_W)
  ) IMAGE_DUT (
    .ramclk (ramclk),
    .n_rst  (n_rst),
    .bus    (bus)
  );

  initial ramclk = 1'b0;
  always #5 ramclk = ~ramclk;

  task automatic tick();
    @(posedge ramclk);
    #1;
  endtask

  function automatic logic [PD-1:0] exp_pix(input int x, input int y);
    int cx;
    int cy;
`ifdef SRAM_IMAGE_CLAMP_EN
    cx = (x < 0) ? 0 : ((x > XM - 1) ? XM - 1 : x);
    cy = (y < 0) ? 0 : ((y > YM - 1) ? YM - 1 : y);
    return mem[cx + cy * XM];
`else
    cx = x;
    cy = y;
    if (cx >= 0 && cx < XM && cy >= 0 && cy < YM) return mem[cx + cy * XM];
    return 8'h00;
`endif
  endfunction

  // Drive one request for one cycle, queueing the pixels it should return.
  task automatic send_burst(input int x, input int y, input int len);
    bus.req       = 1'b1;
    bus.x_start   = COORD_W'(x);
    bus.y_start   = COORD_W'(y);
    bus.burst_len = LEN_W'(len);
    if (len >= 1 && len <= MB) begin
      for (int k = 0; k < len; k++) begin
        exp_q.push_back({(k == len - 1) ? 1'b1 : 1'b0, exp_pix(x + k, y)});
      end
    end
    tick();
    bus.req = 1'b0;
  endtask

  task automatic write_pix(input int x, input int y, input logic [PD-1:0] d);
    bus.wen  = 1'b1;
    bus.w_x  = COORD_W'(x);
    bus.w_y  = COORD_W'(y);
    bus.wdat = d;
    tick();
    bus.wen  = 1'b0;
  endtask

  task automatic wait_drain(input string name, input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    repeat (3) tick();
    total++;
    if (exp_q.size() !== 0) begin
      bad++;
      $display("FAIL %s_drain: %0d pixels still outstanding, required 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset();
    n_rst = 1'b0;
    repeat (2) tick();
    total++;
    if ({bus.busy, bus.rvalid, bus.rlast, bus.rdat, bus.wready} !== {1'b0, 1'b0, 1'b0, 8'h00, 1'b1}) begin
      bad++;
      $display("FAIL reset_state: busy=%b rvalid=%b rlast=%b rdat=%0d wready=%b, required 0 0 0 0 1",
               bus.busy, bus.rvalid, bus.rlast, bus.rdat, bus.wready);
    end
    n_rst = 1'b1;
    tick();
  endtask

  task automatic preload();
    for (int i = 0; i < XM * YM; i++) begin
      mem[i] = PD'(i);
      write_pix(i % XM, i / XM, PD'(i));
    end
  endtask

  task automatic test_reset_mid_burst();
    // Pixels 0 and 1 come back before reset takes effect; the rest must vanish.
    bus.req = 1'b1; bus.x_start = 5'sd0; bus.y_start = 5'sd0; bus.burst_len = 4'd8;
    exp_q.push_back({1'b0, mem[0]});
    exp_q.push_back({1'b0, mem[1]});
    tick();
    bus.req = 1'b0;
    repeat (2) tick();
    n_rst = 1'b0;
    tick();
    total++;
    if ({bus.busy, bus.rvalid, bus.rdat} !== {1'b0, 1'b0, 8'h00}) begin
      bad++;
      $display("FAIL reset_mid_burst: busy=%b rvalid=%b rdat=%0d, required 0 0 0",
               bus.busy, bus.rvalid, bus.rdat);
    end
    tick();
    n_rst = 1'b1;
    repeat (12) tick();
    total++;
    if (bus.busy !== 1'b0) begin
      bad++;
      $display("FAIL reset_no_resume: busy=%b, required 0", bus.busy);
    end
    wait_drain("reset_mid_burst", 5);
  endtask

  task automatic test_basic_burst();
    logic exp_busy [0:4];
    logic exp_rv   [0:4];
    exp_busy = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    exp_rv   = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    send_burst(1, 2, 3);
    for (int i = 0; i < 5; i++) begin
      if (i > 0) tick();
      total++;
      if ({bus.busy, bus.rvalid} !== {exp_busy[i], exp_rv[i]}) begin
        bad++;
        $display("FAIL basic_timing_c%0d: busy=%b rvalid=%b, required %b %b",
                 i + 1, bus.busy, bus.rvalid, exp_busy[i], exp_rv[i]);
      end
    end
    wait_drain("basic", 20);
  endtask

  task automatic test_out_of_frame();
    send_burst(3, -1, 3);
    wait_drain("oob_top", 20);
    send_burst(-2, 4, 3);
    wait_drain("oob_left", 20);
  endtask

  task automatic test_write();
    write_pix(2, 2, 8'hAB);
    mem[2 + 2 * XM] = 8'hAB;
    send_burst(2, 2, 1);
    wait_drain("write_read", 20);
    write_pix(5, 0, 8'hFF);
    write_pix(-1, 1, 8'hEE);
    send_burst(0, 1, 1);
    wait_drain("write_drop_x5", 20);
    send_burst(4, 0, 2);
    wait_drain("write_drop_neg", 20);
  endtask

  task automatic test_back_to_back();
    send_burst(0, 0, 2);
    tick();
    total++;
    if (bus.rvalid !== 1'b1) begin
      bad++;
      $display("FAIL b2b_a0: rvalid=%b, required 1", bus.rvalid);
    end
    tick();
    total++;
    if ({bus.rvalid, bus.rlast, bus.busy} !== 3'b110) begin
      bad++;
      $display("FAIL b2b_a1: rvalid=%b rlast=%b busy=%b, required 1 1 0", bus.rvalid, bus.rlast, bus.busy);
    end
    send_burst(0, 4, 2);
    total++;
    if ({bus.rvalid, bus.busy} !== 2'b01) begin
      bad++;
      $display("FAIL b2b_gap: rvalid=%b busy=%b, required 0 1", bus.rvalid, bus.busy);
    end
    tick();
    total++;
    if (bus.rvalid !== 1'b1) begin
      bad++;
      $display("FAIL b2b_b0: rvalid=%b, required 1", bus.rvalid);
    end
    tick();
    total++;
    if ({bus.rvalid, bus.rlast} !== 2'b11) begin
      bad++;
      $display("FAIL b2b_b1: rvalid=%b rlast=%b, required 1 1", bus.rvalid, bus.rlast);
    end
    wait_drain("b2b", 20);
  endtask

  task automatic test_guards();
    bus.req = 1'b1; bus.x_start = 5'sd0; bus.y_start = 5'sd0; bus.burst_len = 4'd0;
    #1;
    total++;
    if (bus.wready !== 1'b0) begin
      bad++;
      $display("FAIL wready_with_req: wready=%b, required 0", bus.wready);
    end
    send_burst(0, 0, 0);
    total++;
    if (bus.busy !== 1'b0) begin
      bad++;
      $display("FAIL len0_busy: busy=%b, required 0", bus.busy);
    end
    send_burst(0, 0, 9);
    total++;
    if (bus.busy !== 1'b0) begin
      bad++;
      $display("FAIL len9_busy: busy=%b, required 0", bus.busy);
    end
    repeat (4) tick();
    send_burst(0, 3, 3);
    total++;
    if ({bus.busy, bus.wready} !== 2'b10) begin
      bad++;
      $display("FAIL busy_wready: busy=%b wready=%b, required 1 0", bus.busy, bus.wready);
    end
    write_pix(0, 3, 8'h55);
    wait_drain("busy_burst", 20);
    send_burst(0, 3, 1);
    wait_drain("busy_write_dropped", 20);
    send_burst(1, 4, 8);
    wait_drain("max_len", 30);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    n_rst = 1'b0;
    bus.req = 1'b0; bus.x_start = '0; bus.y_start = '0; bus.burst_len = '0;
    bus.wen = 1'b0; bus.w_x = '0; bus.w_y = '0; bus.wdat = '0;

    fork
      forever begin
        @(negedge ramclk);
        if (bus.rvalid === 1'b1) begin
          total++;
          if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL unexpected_rvalid: rdat=%0d rlast=%b, required no rvalid", bus.rdat, bus.rlast);
          end else begin
            mon_e = exp_q.pop_front();
            if ({bus.rlast, bus.rdat} !== mon_e) begin
              bad++;
              $display("FAIL read_pixel: rdat=%0d rlast=%b, required rdat=%0d rlast=%b",
                       bus.rdat, bus.rlast, mon_e[PD-1:0], mon_e[PD]);
            end
          end
        end
      end
    join_none

    test_reset();
    preload();
    test_reset_mid_burst();
    test_basic_burst();
    test_out_of_frame();
    test_write();
    test_back_to_back();
    test_guards();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
